// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the fetch-queue entry layout
package fetch_pkg;
    localparam int ADDR_WIDTH  = 24;
    localparam int INSTR_WIDTH = 32;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic                   pred_taken;
        logic [ADDR_WIDTH-1:0]  pred_target;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   data_valid;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response and decode handshake bundle
//   master = fetch unit side, slave = memory/decode side
interface fetch_if #(
    parameter int ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH
);
    logic                   imem_req_valid;
    logic [ADDR_WIDTH-1:0]  imem_req_addr;
    logic                   imem_req_ready;
    logic                   imem_resp_valid;
    logic [INSTR_WIDTH-1:0] imem_resp_data;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [ADDR_WIDTH-1:0]  dec_pc;
    logic [INSTR_WIDTH-1:0] dec_instr;
    logic                   dec_pred_taken;
    logic [ADDR_WIDTH-1:0]  dec_pred_target;
    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, dec_pred_taken, dec_pred_target,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr, dec_pred_taken, dec_pred_target,
        output imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of in-flight fetches with alloc/fill/pop pointers
//   alloc_*: new entry at tail, fill_*: data into oldest unfilled entry,
//   pop: retire head, flush: empty; count = occupancy, pending = unfilled entries
module fetch_queue #(
    parameter int ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter int DEPTH       = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [ADDR_WIDTH-1:0]    alloc_pc,
    input  logic                     alloc_taken,
    input  logic [ADDR_WIDTH-1:0]    alloc_target,
    input  logic                     fill,
    input  logic [INSTR_WIDTH-1:0]   fill_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [ADDR_WIDTH-1:0]    head_pc,
    output logic [INSTR_WIDTH-1:0]   head_instr,
    output logic                     head_taken,
    output logic [ADDR_WIDTH-1:0]    head_target,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int PW = $clog2(DEPTH);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic                   pred_taken;
        logic [ADDR_WIDTH-1:0]  pred_target;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   data_valid;
    } entry_t;
    entry_t mem [DEPTH];
    // pointers carry an extra wrap bit so full and empty are distinguishable
    logic [PW:0] wp, fp, rp;
    assign count       = wp - rp;
    assign pending     = wp - fp;
    assign head_valid  = (wp != rp) && mem[rp[PW-1:0]].data_valid;
    assign head_pc     = mem[rp[PW-1:0]].pc;
    assign head_instr  = mem[rp[PW-1:0]].instr;
    assign head_taken  = mem[rp[PW-1:0]].pred_taken;
    assign head_target = mem[rp[PW-1:0]].pred_target;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0;
            fp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wp <= '0;
            fp <= '0;
            rp <= '0;
        end else begin
            if (alloc) begin
                mem[wp[PW-1:0]] <= '{pc: alloc_pc, pred_taken: alloc_taken, pred_target: alloc_target,
                                     instr: '0, data_valid: 1'b0};
                wp <= wp + 1'b1;
            end
            if (fill) begin
                mem[fp[PW-1:0]].instr      <= fill_data;
                mem[fp[PW-1:0]].data_valid <= 1'b1;
                fp <= fp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation with BTB prediction, imem request issue and fetch queue to decode
//   clk/reset_n: clock, async active-low reset
//   btb_pc/btb_hit/btb_target: BTB lookup of the current pc
//   redirect_valid/redirect_pc: flush and restart from execute
//   bus (fetch_if.master): imem request/response and decode handshake
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 4,
    parameter int                    DEPTH       = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] btb_pc,
    input  logic                  btb_hit,
    input  logic [ADDR_WIDTH-1:0] btb_target,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    fetch_if.master               bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0] drop_cnt, count, pending;
    logic accept, fill, pop;
    assign btb_pc             = pc;
    assign bus.imem_req_addr  = pc;
    // responses still owed to the memory (dropped or queued) bound new requests
    assign bus.imem_req_valid = reset_n && !redirect_valid && ({1'b0, count} + {1'b0, drop_cnt} < LIMIT);
    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    assign fill   = bus.imem_resp_valid && drop_cnt == '0 && !redirect_valid;
    assign pop    = bus.dec_valid && bus.dec_ready && !redirect_valid;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            // a response arriving now retires the oldest outstanding request
            drop_cnt <= drop_cnt + pending - CW'(bus.imem_resp_valid);
        end else begin
            if (accept) pc <= btb_hit ? btb_target : pc + ADDR_WIDTH'(PC_STEP);
            if (bus.imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        end
    end
    fetch_queue #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH), .DEPTH(DEPTH)) queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (redirect_valid),
        .alloc       (accept),
        .alloc_pc    (pc),
        .alloc_taken (btb_hit),
        .alloc_target(btb_target),
        .fill        (fill),
        .fill_data   (bus.imem_resp_data),
        .pop         (pop),
        .head_valid  (bus.dec_valid),
        .head_pc     (bus.dec_pc),
        .head_instr  (bus.dec_instr),
        .head_taken  (bus.dec_pred_taken),
        .head_target (bus.dec_pred_target),
        .count       (count),
        .pending     (pending)
    );
    resp_has_owner: assert property (@(posedge clk) disable iff (!reset_n)
        bus.imem_resp_valid |-> (drop_cnt != '0 || pending != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, reset sequence and randomized run against a queue model
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = 2;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;
    localparam logic Y = 1'b1, N = 1'b0;
    localparam addr_t Z = '0;
    localparam instr_t ZI = '0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    addr_t btb_pc, btb_target, redirect_pc;
    logic btb_hit, redirect_valid;
    fetch_if #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) bus ();
    fetch_unit #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_WIDTH(INSTR_WIDTH), .RESET_PC(24'h0),
                 .PC_STEP(4), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btb_pc        (btb_pc),
        .btb_hit       (btb_hit),
        .btb_target    (btb_target),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t d(input addr_t a);
        return 32'hC000_0000 | {8'h00, a};
    endfunction

    task automatic drive(input logic hit, input addr_t tgt, input logic rdy, input logic rv,
                         input instr_t rdata, input logic dr, input logic rd, input addr_t rpc);
        btb_hit = hit;
        btb_target = tgt;
        bus.imem_req_ready = rdy;
        bus.imem_resp_valid = rv;
        bus.imem_resp_data = rdata;
        bus.dec_ready = dr;
        redirect_valid = rd;
        redirect_pc = rpc;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'(0));
        chk("rst_req_addr", 64'(bus.imem_req_addr), 64'(0));
        chk("rst_btb_pc", 64'(btb_pc), 64'(0));
        chk("rst_dec_valid", 64'(bus.dec_valid), 64'(0));
        chk("rst_dec_pc", 64'(bus.dec_pc), 64'(0));
        chk("rst_dec_instr", 64'(bus.dec_instr), 64'(0));
        chk("rst_dec_taken", 64'(bus.dec_pred_taken), 64'(0));
        chk("rst_dec_target", 64'(bus.dec_pred_target), 64'(0));
    endtask

    typedef struct {
        logic hit; addr_t tgt; logic rdy; logic rv; instr_t rdata; logic dr; logic rd; addr_t rpc;
        logic e_rv; addr_t e_addr; logic e_dv; addr_t e_pc; instr_t e_instr; logic e_tk; addr_t e_tg;
    } vec_t;
    vec_t tv[20];

    typedef struct { instr_t data; int due; } resp_t;
    resp_t memq[$];
    fetch_entry_t mq[$];
    addr_t m_pc;
    int m_drop;

    initial begin
        logic e_rv, e_dv, rv, acc, pop;
        resp_t r;
        fetch_entry_t e;
        int unf;
        tv[0]  = '{N,Z,Y,N,ZI,Y,N,Z,                 Y,24'h000000,N,Z,ZI,N,Z};
        tv[1]  = '{N,Z,Y,Y,d(24'h0),Y,N,Z,           Y,24'h000004,N,Z,ZI,N,Z};
        tv[2]  = '{N,Z,Y,Y,d(24'h4),Y,N,Z,           N,24'h000008,Y,24'h000000,d(24'h0),N,Z};
        tv[3]  = '{Y,24'h100,Y,N,ZI,Y,N,Z,           Y,24'h000008,Y,24'h000004,d(24'h4),N,Z};
        tv[4]  = '{N,Z,Y,Y,d(24'h8),Y,N,Z,           Y,24'h000100,N,Z,ZI,N,Z};
        tv[5]  = '{N,Z,Y,Y,d(24'h100),N,N,Z,         N,24'h000104,Y,24'h000008,d(24'h8),Y,24'h100};
        tv[6]  = '{N,Z,Y,N,ZI,N,N,Z,                 N,24'h000104,Y,24'h000008,d(24'h8),Y,24'h100};
        tv[7]  = '{N,Z,Y,N,ZI,Y,N,Z,                 N,24'h000104,Y,24'h000008,d(24'h8),Y,24'h100};
        tv[8]  = '{N,Z,Y,N,ZI,N,N,Z,                 Y,24'h000104,Y,24'h000100,d(24'h100),N,Z};
        tv[9]  = '{N,Z,Y,N,ZI,Y,N,Z,                 N,24'h000108,Y,24'h000100,d(24'h100),N,Z};
        tv[10] = '{N,Z,Y,N,ZI,Y,N,Z,                 Y,24'h000108,N,Z,ZI,N,Z};
        tv[11] = '{N,Z,Y,N,ZI,Y,Y,24'h000040,        N,24'h00010C,N,Z,ZI,N,Z};
        tv[12] = '{N,Z,Y,Y,d(24'h104),Y,N,Z,         N,24'h000040,N,Z,ZI,N,Z};
        tv[13] = '{N,Z,Y,Y,d(24'h108),Y,N,Z,         Y,24'h000040,N,Z,ZI,N,Z};
        tv[14] = '{N,Z,N,Y,d(24'h40),Y,N,Z,          Y,24'h000044,N,Z,ZI,N,Z};
        tv[15] = '{N,Z,N,N,ZI,Y,N,Z,                 Y,24'h000044,Y,24'h000040,d(24'h40),N,Z};
        tv[16] = '{N,Z,Y,N,ZI,Y,Y,24'hFFFFFC,        N,24'h000044,N,Z,ZI,N,Z};
        tv[17] = '{N,Z,Y,N,ZI,Y,N,Z,                 Y,24'hFFFFFC,N,Z,ZI,N,Z};
        tv[18] = '{N,Z,N,Y,d(24'hFFFFFC),Y,N,Z,      Y,24'h000000,N,Z,ZI,N,Z};
        tv[19] = '{N,Z,N,N,ZI,Y,N,Z,                 Y,24'h000000,Y,24'hFFFFFC,d(24'hFFFFFC),N,Z};

        drive(N, Z, N, N, ZI, N, N, Z);
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tv[i].hit, tv[i].tgt, tv[i].rdy, tv[i].rv, tv[i].rdata, tv[i].dr, tv[i].rd, tv[i].rpc);
            #1;
            chk($sformatf("v%0d_req_valid", i), 64'(bus.imem_req_valid), 64'(tv[i].e_rv));
            chk($sformatf("v%0d_req_addr", i), 64'(bus.imem_req_addr), 64'(tv[i].e_addr));
            chk($sformatf("v%0d_btb_pc", i), 64'(btb_pc), 64'(tv[i].e_addr));
            chk($sformatf("v%0d_dec_valid", i), 64'(bus.dec_valid), 64'(tv[i].e_dv));
            if (tv[i].e_dv) begin
                chk($sformatf("v%0d_dec_pc", i), 64'(bus.dec_pc), 64'(tv[i].e_pc));
                chk($sformatf("v%0d_dec_instr", i), 64'(bus.dec_instr), 64'(tv[i].e_instr));
                chk($sformatf("v%0d_dec_taken", i), 64'(bus.dec_pred_taken), 64'(tv[i].e_tk));
                chk($sformatf("v%0d_dec_target", i), 64'(bus.dec_pred_target), 64'(tv[i].e_tg));
            end
        end

        // mid-stream reset: two requests issued, one filled, then reset_n drops
        @(negedge clk);
        drive(N, Z, Y, N, ZI, N, N, Z);
        @(negedge clk);
        drive(N, Z, Y, Y, d(24'h0), N, N, Z);
        @(negedge clk);
        drive(N, Z, N, N, ZI, N, N, Z);
        #1 chk("mid_dec_valid_before_reset", 64'(bus.dec_valid), 64'(1));
        reset_n = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        #1;
        chk("post_reset_req_valid", 64'(bus.imem_req_valid), 64'(1));
        chk("post_reset_req_addr", 64'(bus.imem_req_addr), 64'(0));

        // randomized run against the queue model, from a fresh reset
        @(negedge clk);
        drive(N, Z, N, N, ZI, N, N, Z);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        memq.delete();
        mq.delete();
        m_pc = '0;
        m_drop = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 4) == 0) ? 24'hFFFFF8 : (addr_t'($urandom) & 24'hFFFFFC);
            btb_hit = ($urandom_range(0, 3) == 0);
            btb_target = addr_t'($urandom) & 24'hFFFFFC;
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            bus.dec_ready = ($urandom_range(0, 9) < 6);
            rv = 1'b0;
            bus.imem_resp_data = '0;
            if (memq.size() > 0 && memq[0].due <= c && $urandom_range(0, 9) < 7) begin
                r = memq.pop_front();
                rv = 1'b1;
                bus.imem_resp_data = r.data;
            end
            bus.imem_resp_valid = rv;
            #1;
            e_rv = !redirect_valid && (mq.size() + m_drop < DEPTH);
            e_dv = mq.size() > 0 && mq[0].data_valid;
            chk("rnd_req_valid", 64'(bus.imem_req_valid), 64'(e_rv));
            chk("rnd_req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
            chk("rnd_dec_valid", 64'(bus.dec_valid), 64'(e_dv));
            if (e_dv) begin
                chk("rnd_dec_pc", 64'(bus.dec_pc), 64'(mq[0].pc));
                chk("rnd_dec_instr", 64'(bus.dec_instr), 64'(mq[0].instr));
                chk("rnd_dec_taken", 64'(bus.dec_pred_taken), 64'(mq[0].pred_taken));
                chk("rnd_dec_target", 64'(bus.dec_pred_target), 64'(mq[0].pred_target));
            end
            @(posedge clk);
            acc = e_rv && bus.imem_req_ready;
            if (acc) memq.push_back('{d(m_pc), c + 1 + int'($urandom_range(0, 2))});
            if (redirect_valid) begin
                unf = 0;
                foreach (mq[k]) if (!mq[k].data_valid) unf++;
                m_drop = m_drop + unf - int'(rv);
                mq.delete();
                m_pc = redirect_pc;
            end else begin
                pop = e_dv && bus.dec_ready;
                if (rv) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        for (int k = 0; k < mq.size(); k++) begin
                            if (!mq[k].data_valid) begin
                                e = mq[k];
                                e.instr = bus.imem_resp_data;
                                e.data_valid = 1'b1;
                                mq[k] = e;
                                break;
                            end
                        end
                    end
                end
                if (pop) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back('{pc: m_pc, pred_taken: btb_hit, pred_target: btb_target,
                                   instr: '0, data_valid: 1'b0});
                    m_pc = btb_hit ? btb_target : m_pc + 24'd4;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, PC/address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-005 SHALL have parameter DEPTH, default 2, fetch queue entries (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port btb_pc, output, ADDR_WIDTH, lookup PC driven to the BTB, equal to the current pc register.
REQ-009 SHALL have port btb_hit, input, 1, BTB prediction for btb_pc.
REQ-010 SHALL have port btb_target, input, ADDR_WIDTH, predicted target when btb_hit.
REQ-011 SHALL have port redirect_valid, input, 1, mispredict/flush from execute.
REQ-012 SHALL have port redirect_pc, input, ADDR_WIDTH, corrected PC.
REQ-013 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-014 SHALL have port imem_req_addr, output, ADDR_WIDTH, fetch address, equal to pc.
REQ-015 SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-016 SHALL have port imem_resp_valid, input, 1, in-order response, one per accepted request, latency >=1 cycle.
REQ-017 SHALL have port imem_resp_data, input, INSTR_WIDTH, fetched instruction.
REQ-018 SHALL have port dec_valid, output, 1, instruction available to decode.
REQ-019 SHALL have port dec_ready, input, 1, decode accepts.
REQ-020 SHALL have ports dec_pc (ADDR_WIDTH), dec_instr (INSTR_WIDTH), dec_pred_taken (1), dec_pred_target (ADDR_WIDTH), all outputs, head-entry payload.

Function
REQ-021 Request handshake SHALL complete on a cycle with imem_req_valid && imem_req_ready.
REQ-022 imem_req_valid SHALL be 1 only when !redirect_valid and (queue occupancy + drop_cnt) < DEPTH.
REQ-023 On an accepted request, pc SHALL become btb_target if btb_hit, else pc+PC_STEP (modulo 2^ADDR_WIDTH, wraps silently).
REQ-024 On an accepted request, a queue entry SHALL be allocated holding {pc, btb_hit, btb_target, data_valid=0}.
REQ-025 Without acceptance or redirect, pc SHALL hold; imem_req_addr SHALL remain stable while imem_req_valid && !imem_req_ready.
REQ-026 A response SHALL be discarded and drop_cnt decremented when drop_cnt>0; otherwise it SHALL fill the oldest unfilled entry (data_valid=1).
REQ-027 dec_valid SHALL equal data_valid of the head entry; pop on dec_valid && dec_ready.
REQ-028 Same-cycle allocate, fill and pop SHALL all take effect; occupancy never exceeds DEPTH.
REQ-029 On redirect_valid, pc SHALL load redirect_pc next cycle, the queue SHALL empty, and drop_cnt SHALL load the count of outstanding unfilled requests, excluding any response arriving that cycle.
REQ-030 redirect_valid SHALL take priority over request acceptance, response fill and decode pop in the same cycle; dec_valid SHALL be 0 the cycle after redirect.
REQ-031 Fetch-to-decode latency SHALL be one cycle: response in cycle N -> dec_valid in N+1.
REQ-032 A response with no allocated entry and drop_cnt=0 is a protocol violation; an assertion SHALL flag it.

Reset
REQ-033 While reset_n=0, pc SHALL be RESET_PC; queue empty; drop_cnt=0.
REQ-034 Reset outputs SHALL be: imem_req_valid=0, dec_valid=0, btb_pc=imem_req_addr=RESET_PC, dec_pc/dec_instr/dec_pred_taken/dec_pred_target=0.
REQ-035 Reset assertion mid-operation SHALL abandon all outstanding requests; the bench must not deliver stale responses afterwards.

Structure
REQ-036 Package fetch_pkg SHALL hold ADDR_WIDTH, INSTR_WIDTH and the queue-entry type {pc, pred_taken, pred_target, instr, data_valid}.
REQ-037 Sub-module fetch_queue SHALL implement the circular buffer (alloc/fill/pop pointers, flush); pc and drop_cnt logic SHALL live in fetch_unit.

Verification
REQ-038 Reset release, btb_hit=0, ready=1, 1-cycle memory -> addresses 0x000000, 0x000004, 0x000008; dec_pc matches in order.
REQ-039 btb_hit=1, btb_target=0x000100 at pc 0x000008 -> next request 0x000100; dec_pred_taken=1, dec_pred_target=0x000100 for pc 0x000008.
REQ-040 dec_ready=0 with DEPTH=2 -> exactly 2 requests issued, imem_req_valid=0 until pop; no entry lost.
REQ-041 redirect_pc=0x000040 with 2 responses outstanding -> both responses dropped, next request 0x000040, first dec_pc=0x000040.
REQ-042 pc=0xFFFFFC, btb_hit=0 -> next request 0x000000.
REQ-043 reset_n pulsed low mid-stream -> all outputs at reset values immediately, first request RESET_PC after release.
